// File: rtl/exc_sequencer.sv
// Exception/ERET sequencer: flushes younger stages and redirects fetch to the handler or EPC.
// Latency: flush/kill same cycle as the request; pc_load rises on the next edge (1 cycle).
// Backpressure: redirect is held until fetch_ready; requests are ignored while a redirect is pending.
module exc_sequencer #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
    parameter int          CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             kernel_req,
    input  logic             eret_m,
    input  logic [31:0]      epc,
    input  logic             md_busy,
    input  logic             fetch_ready,
    output logic             flush_fde,
    output logic             kill_m,
    output logic             pc_load,
    output logic [31:0]      pc_redirect,
    output logic             md_cancel,
    output logic             busy,
    output logic [CNT_W-1:0] trap_cnt,
    output logic [CNT_W-1:0] eret_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TRAP = 2'd1,
        RET  = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   take_trap;
    logic   take_eret;
    logic   handoff;

    always_comb begin
        state_nxt = state;
        flush_fde = 1'b0;
        kill_m    = 1'b0;
        take_trap = 1'b0;
        take_eret = 1'b0;
        handoff   = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    // Trap has priority; a concurrent eret is dropped, as in CP0.
                    if (kernel_req) begin
                        take_trap = 1'b1;
                        flush_fde = 1'b1;
                        kill_m    = 1'b1;
                        state_nxt = TRAP;
                    end else if (eret_m) begin
                        take_eret = 1'b1;
                        flush_fde = 1'b1;
                        state_nxt = RET;
                    end
                end
                TRAP, RET: begin
                    flush_fde = 1'b1;
                    if (fetch_ready) begin
                        handoff   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            pc_load     <= 1'b0;
            pc_redirect <= 32'h0;
            md_cancel   <= 1'b0;
            trap_cnt    <= '0;
            eret_cnt    <= '0;
        end else begin
            state     <= state_nxt;
            md_cancel <= take_trap & md_busy;
            if (take_trap) begin
                pc_load     <= 1'b1;
                pc_redirect <= HANDLER_ADDR;
                trap_cnt    <= trap_cnt + CNT_W'(1);
            end else if (take_eret) begin
                pc_load     <= 1'b1;
                pc_redirect <= epc;
                eret_cnt    <= eret_cnt + CNT_W'(1);
            end else if (handoff) begin
                pc_load <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_exc_sequencer.sv
// Bench for exc_sequencer: directed vector table, hand-written corner sequences and random traffic.
module tb_exc_sequencer;

    localparam int          CNT_W   = 4;
    localparam int          CNT_MOD = 1 << CNT_W;
    localparam logic [31:0] HANDLER = 32'h0000_4180;

    logic             clock = 1'b0;
    logic             reset;
    logic             kernel_req, eret_m, md_busy, fetch_ready;
    logic [31:0]      epc;
    logic             flush_fde, kill_m, pc_load, md_cancel, busy;
    logic [31:0]      pc_redirect;
    logic [CNT_W-1:0] trap_cnt, eret_cnt;

    int checks = 0;
    int errors = 0;

    exc_sequencer #(.HANDLER_ADDR(HANDLER), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .kernel_req(kernel_req), .eret_m(eret_m),
        .epc(epc), .md_busy(md_busy), .fetch_ready(fetch_ready),
        .flush_fde(flush_fde), .kill_m(kill_m), .pc_load(pc_load),
        .pc_redirect(pc_redirect), .md_cancel(md_cancel), .busy(busy),
        .trap_cnt(trap_cnt), .eret_cnt(eret_cnt)
    );

    always #5 clock = ~clock;

    // Reference: a redirect is either pending (with its target) or not.
    bit          m_pending;
    logic [31:0] m_redirect;
    bit          m_cancel;
    int          m_traps, m_erets;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_pending  = 0;
        m_redirect = 32'h0;
        m_cancel   = 0;
        m_traps    = 0;
        m_erets    = 0;
    endtask

    task automatic check_model();
        bit req_ok;
        req_ok = !reset && !m_pending;
        chk("flush_fde", flush_fde, !reset && (m_pending || kernel_req || eret_m));
        chk("kill_m", kill_m, req_ok && kernel_req);
        chk("pc_load", pc_load, m_pending);
        chk("pc_redirect", pc_redirect, m_redirect);
        chk("md_cancel", md_cancel, m_cancel);
        chk("busy", busy, m_pending);
        chk("trap_cnt", trap_cnt, m_traps % CNT_MOD);
        chk("eret_cnt", eret_cnt, m_erets % CNT_MOD);
    endtask

    task automatic model_edge();
        if (reset) begin
            model_clear();
        end else if (m_pending) begin
            m_cancel = 0;
            if (fetch_ready) m_pending = 0;
        end else begin
            m_cancel = kernel_req && md_busy;
            if (kernel_req) begin
                m_pending  = 1;
                m_redirect = HANDLER;
                m_traps    = (m_traps + 1) % CNT_MOD;
            end else if (eret_m) begin
                m_pending  = 1;
                m_redirect = epc;
                m_erets    = (m_erets + 1) % CNT_MOD;
            end
        end
    endtask

    // Applies one cycle of inputs (entered at posedge+1), checks mid-cycle, returns at posedge+1.
    task automatic cycle(input logic kr, input logic er, input logic mb, input logic fr,
                         input logic [31:0] pc);
        kernel_req  = kr;
        eret_m      = er;
        md_busy     = mb;
        fetch_ready = fr;
        epc         = pc;
        @(negedge clock);
        check_model();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    typedef struct {
        logic        kr, er, mb, fr;
        logic [31:0] pc;
        logic        e_flush, e_kill, e_pl;
        logic [31:0] e_redir;
        logic        e_mdc, e_busy;
        int          e_tcnt, e_ecnt;
    } vec_t;

    vec_t vecs[7];
    int   pl_cycles;
    int   tr_before;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0,      1'b1, 1'b1, 1'b0, 32'h0,   1'b0, 1'b0, 0, 0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,      1'b1, 1'b0, 1'b1, HANDLER, 1'b0, 1'b1, 1, 0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,      1'b0, 1'b0, 1'b0, HANDLER, 1'b0, 1'b0, 1, 0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h3010,   1'b1, 1'b0, 1'b0, HANDLER, 1'b0, 1'b0, 1, 0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,      1'b1, 1'b0, 1'b1, 32'h3010, 1'b0, 1'b1, 1, 1};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,      1'b1, 1'b0, 1'b1, 32'h3010, 1'b0, 1'b1, 1, 1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,      1'b0, 1'b0, 1'b0, 32'h3010, 1'b0, 1'b0, 1, 1};

        // Reset with a request present: combinational outputs must stay low.
        model_clear();
        reset = 1'b1;
        @(posedge clock); #1;
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'hdead_beef);
        chk("rst_pc_load", pc_load, 1'b0);
        chk("rst_redirect", pc_redirect, 32'h0);
        reset = 1'b0;

        // Trap entry then ERET return from the vector table.
        foreach (vecs[i]) begin
            kernel_req  = vecs[i].kr;
            eret_m      = vecs[i].er;
            md_busy     = vecs[i].mb;
            fetch_ready = vecs[i].fr;
            epc         = vecs[i].pc;
            @(negedge clock);
            chk($sformatf("v%0d_flush", i), flush_fde, vecs[i].e_flush);
            chk($sformatf("v%0d_kill", i), kill_m, vecs[i].e_kill);
            chk($sformatf("v%0d_pc_load", i), pc_load, vecs[i].e_pl);
            chk($sformatf("v%0d_redirect", i), pc_redirect, vecs[i].e_redir);
            chk($sformatf("v%0d_md_cancel", i), md_cancel, vecs[i].e_mdc);
            chk($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
            chk($sformatf("v%0d_trap_cnt", i), trap_cnt, vecs[i].e_tcnt);
            chk($sformatf("v%0d_eret_cnt", i), eret_cnt, vecs[i].e_ecnt);
            @(posedge clock);
            model_edge();
            #1;
        end

        // Fetch stall: redirect held 4 cycles, idle on the 5th.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        pl_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (pc_load && pc_redirect == HANDLER && busy) pl_cycles++;
            cycle(1'b0, 1'b0, 1'b0, (i == 3), 32'h0);
        end
        chk("stall_hold_cycles", pl_cycles, 4);
        chk("stall_idle_busy", busy, 1'b0);

        // Simultaneous trap+eret with mult/div busy.
        tr_before = m_erets;
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_7777);
        chk("simul_md_cancel", md_cancel, 1'b1);
        chk("simul_redirect", pc_redirect, HANDLER);
        chk("simul_eret_cnt", eret_cnt, tr_before);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h0);
        chk("simul_md_cancel_drop", md_cancel, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

        // Requests ignored while a redirect is pending, then reset mid-sequence.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        tr_before = m_traps;
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h1234_5678);
        chk("busy_trap_cnt", trap_cnt, tr_before);
        chk("busy_redirect", pc_redirect, HANDLER);
        reset = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        chk("midrst_pc_load", pc_load, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_trap_cnt", trap_cnt, 0);
        chk("midrst_eret_cnt", eret_cnt, 0);

        // Counter wrap at 2^CNT_W.
        for (int i = 0; i < CNT_MOD - 1; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
            cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        end
        chk("wrap_at_max", trap_cnt, CNT_MOD - 1);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        chk("wrap_to_zero", trap_cnt, 0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

        // Random traffic against the reference.
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(63) == 0);
            cycle(($urandom_range(3) == 0), ($urandom_range(3) == 0), $urandom_range(1),
                  $urandom_range(1), $urandom);
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exc_sequencer.md
Name: exc_sequencer

Overview:
- Pipeline-side controller that sequences exception/interrupt entry and ERET return around the CP0 block.
- Watches CP0's kernel request and the M-stage eret flag, flushes younger pipeline stages, and drives the fetch PC redirect to the handler or to EPC.
- Holds the redirect until fetch accepts it, cancels an in-flight mult/div operation on trap entry, and keeps debug event counters.

Parameters:
- HANDLER_ADDR, 32'h0000_4180, exception/interrupt handler entry PC.
- CNT_W, 16, width of the trap and eret event counters.

Ports:
- clock  in  1  system clock. Single clock domain; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high reset.
- kernel_req  in  1  CP0 kernel output (interrupt or exception accepted this cycle, M level).
- eret_m  in  1  eret instruction is in M this cycle.
- epc  in  32  CP0 EPC output.
- md_busy  in  1  mult/div unit busy.
- fetch_ready  in  1  F stage can load a new PC this cycle.
- flush_fde  out  1  kill F, D and E stage contents (combinational).
- kill_m  out  1  suppress M-stage memory write of the trapping instruction (combinational).
- pc_load  out  1  force next PC to pc_redirect (registered).
- pc_redirect  out  32  target PC (registered).
- md_cancel  out  1  one-cycle abort pulse to mult/div (registered).
- busy  out  1  high whenever state != IDLE.
- trap_cnt  out  CNT_W  number of accepted traps, wraps.
- eret_cnt  out  CNT_W  number of accepted erets, wraps.

Behaviour:
- Reset values: state=IDLE, pc_load=0, pc_redirect=0, md_cancel=0, counters=0. flush_fde and kill_m are 0 while reset is high.
- States:
  - IDLE: no redirect pending.
  - TRAP: redirect to HANDLER_ADDR pending.
  - RET: redirect to the EPC captured at eret pending.
- Request acceptance applies in IDLE only; evaluate the rules in order.
  - kernel_req=1, trap accepted:
    - Same cycle: flush_fde=1 and kill_m=1.
    - Next edge: state←TRAP, pc_redirect←HANDLER_ADDR, pc_load←1, trap_cnt+1.
    - md_cancel←1 for exactly one cycle if md_busy=1 on the request cycle.
  - else if eret_m=1, return accepted:
    - Same cycle: flush_fde=1; kill_m=0.
    - Next edge: state←RET, pc_redirect←epc sampled that cycle, pc_load←1, eret_cnt+1.
  - kernel_req and eret_m both high: trap wins and eret is dropped. This matches CP0, where trap priority suppresses eret.
- TRAP/RET hold:
  - pc_load and pc_redirect stay constant while fetch_ready=0.
  - The first cycle with fetch_ready=1 and pc_load=1 is the handoff. Next edge: pc_load←0, state←IDLE.
  - Minimum redirect latency is 1 cycle from the request cycle to pc_load=1.
- While state≠IDLE:
  - flush_fde=1 every cycle, including the handoff cycle, so no wrong-path instruction enters D.
  - kill_m=0.
  - kernel_req and eret_m are ignored. CP0 EXL blocks re-entry; anything in M is a flushed bubble.
- A new request is accepted no earlier than the cycle after state returns to IDLE.
- md_cancel is cleared on the edge after it is set, independent of state.
- Counters wrap from 2^CNT_W−1 to 0 with no saturation.
- Reset mid-sequence: the next edge returns everything to reset values. A pending redirect is discarded.

Test Plan:
- Trap entry:
  - Stimulus: IDLE; kernel_req=1 for 1 cycle; fetch_ready=1; md_busy=0.
  - Response: that cycle flush_fde=1, kill_m=1. Next cycle pc_load=1, pc_redirect=32'h0000_4180, trap_cnt=1, md_cancel=0. Following cycle pc_load=0, busy=0.
- ERET return:
  - Stimulus: eret_m=1, epc=32'h0000_3010.
  - Response: flush_fde=1, kill_m=0. Next cycle pc_redirect=32'h0000_3010, pc_load=1, eret_cnt=1.
- Fetch stall:
  - Stimulus: trap accepted with fetch_ready=0 for 3 cycles, then 1.
  - Response: pc_load=1 and pc_redirect=HANDLER_ADDR held for 4 cycles with flush_fde=1 throughout; IDLE on the 5th cycle.
- Simultaneous request plus mult/div cancel:
  - Stimulus: kernel_req=1, eret_m=1, md_busy=1 in the same cycle.
  - Response: TRAP taken, pc_redirect=HANDLER_ADDR, eret_cnt unchanged, md_cancel high for exactly 1 cycle.
- Ignore while busy:
  - Stimulus: kernel_req pulses during TRAP with fetch_ready=0.
  - Response: trap_cnt stays 1 and pc_redirect is unchanged. Reset asserted in TRAP gives pc_load=0, state=IDLE, counters=0 on the next cycle.
- Counter wrap:
  - Stimulus: CNT_W=4, 16 trap sequences.
  - Response: trap_cnt goes 15→0.
